// File: rtl/iobus_uart_tx_pkg.sv
// uart_types: shared state encoding, register offsets and STATUS bit positions for the IOBUS UART
package uart_types;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;
endpackage

// File: rtl/iobus_uart_tx_fifo.sv
// otter_sync_fifo: show-ahead synchronous FIFO
// Ports: i_clk, i_rst_n (async active-low), i_push/i_din write side, i_pop read side,
//        o_dout (head entry), o_full, o_empty, o_count (entries held).
// A push while full is accepted only when a pop happens in the same cycle.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_wr, w_rd;
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_dout  = r_mem[r_rp];
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: MMIO 8N1 UART transmitter with TX FIFO, answering OTTER IOBUS loads/stores
// Ports: CLK, RESET_N (async active-low), IOBUS_ADDR/IOBUS_OUT/IOBUS_WR from the CPU MEM stage,
//        IOBUS_IN combinational load data (0 outside the window), TX serial line, IRQ drained level.
module iobus_uart_tx
    import uart_types::*;
#(
    parameter int          CLK_RATE   = 50,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        IRQ
);
    localparam int DIV = (CLK_RATE * 1_000_000 + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DW  = $clog2(DIV + 1);
    tx_state_t     r_state, w_state_nxt;
    logic [DW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_sh, w_sh_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_ovf, r_ie, r_irq;
    logic [31:0]   w_ofs, w_status;
    logic [3:0]    w_reg;
    logic          w_hit, w_wr_data, w_wr_status, w_wr_ctrl, w_ie_nxt, w_tick, w_pop;
    logic          w_full, w_empty, w_unused;
    logic [7:0]    w_dout;
    logic [CW-1:0] w_count;
    // Window is decoded by word; +12 and beyond fall outside.
    assign w_ofs       = IOBUS_ADDR - BASE_ADDR;
    assign w_hit       = w_ofs < 32'd12;
    assign w_reg       = {w_ofs[3:2], 2'b00};
    assign w_wr_data   = IOBUS_WR & w_hit & (w_reg == DATA_OFS);
    assign w_wr_status = IOBUS_WR & w_hit & (w_reg == STATUS_OFS);
    assign w_wr_ctrl   = IOBUS_WR & w_hit & (w_reg == CTRL_OFS);
    assign w_ie_nxt    = w_wr_ctrl ? IOBUS_OUT[0] : r_ie;
    assign w_tick      = r_cnt == DW'(DIV - 1);
    assign w_unused    = &{1'b0, IOBUS_OUT[31:8], w_ofs[1:0]};
    assign TX          = r_tx;
    assign IRQ         = r_irq;
    otter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_din   (IOBUS_OUT[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
            r_ie    <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_sh    <= w_sh_nxt;
            r_tx    <= w_tx_nxt;
            r_ie    <= w_ie_nxt;
            r_ovf   <= (w_wr_data & w_full & ~w_pop) ? 1'b1 :
                       (w_wr_status & IOBUS_OUT[STAT_OVF]) ? 1'b0 : r_ovf;
            // A push or ie=0 in this cycle drops IRQ at this same edge.
            r_irq   <= w_ie_nxt & w_empty & (r_state == IDLE) & ~w_wr_data;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? '0 : r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = w_empty;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_dout;
                    w_state_nxt = START;
                end
            end
            START: if (w_tick) begin
                w_tx_nxt    = r_sh[0];
                w_bit_nxt   = '0;
                w_state_nxt = DATA;
            end
            DATA: if (w_tick) begin
                if (r_bit == 3'd7) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = STOP;
                end else begin
                    w_sh_nxt  = r_sh >> 1;
                    w_tx_nxt  = r_sh[1];
                    w_bit_nxt = r_bit + 1'b1;
                end
            end
            STOP: if (w_tick) begin
                // Back-to-back frames: next start bit follows the stop bit with no idle gap.
                w_pop       = ~w_empty;
                w_sh_nxt    = w_empty ? r_sh : w_dout;
                w_tx_nxt    = w_empty;
                w_state_nxt = w_empty ? IDLE : START;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_comb begin
        w_status                  = '0;
        w_status[STAT_BUSY]       = (r_state != IDLE) | ~w_empty;
        w_status[STAT_FULL]       = w_full;
        w_status[STAT_EMPTY]      = w_empty;
        w_status[STAT_OVF]        = r_ovf;
        w_status[STAT_CNT +: CW]  = w_count;
        IOBUS_IN = !w_hit                  ? 32'd0 :
                   (w_reg == STATUS_OFS)   ? w_status :
                   (w_reg == CTRL_OFS)     ? {31'd0, r_ie} : 32'd0;
    end
endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb_iobus_uart_tx: directed self-checking bench for iobus_uart_tx at DIV=4
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE = 32'h1100_0100;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic [31:0] IOBUS_IN;
    logic        TX, IRQ;
    int          n_tests = 0;
    int          n_fail = 0;
    int          rx_bad = 0;
    bit          mon_en = 1'b0;
    bit          done;
    logic [7:0]  rx_q [$];
    logic [7:0]  mon_b;
    logic [31:0] rd_v;

    iobus_uart_tx #(.CLK_RATE(1), .BAUD(250000), .BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .IRQ        (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        IOBUS_ADDR = a;
        #1 d = IOBUS_IN;
    endtask

    // bits holds the expected line, LSB first, one entry per 4-cycle bit; k counts edges since the push.
    task automatic check_line(input string tag, input logic [19:0] bits, input int nb, input int k0);
        for (int k = k0; k <= nb * 4; k++) begin
            @(negedge CLK);
            check(tag, 32'(TX), 32'(bits[(k - 1) / 4]));
        end
    endtask

    // Independent 8N1 receiver sampling mid-bit.
    initial forever begin
        @(negedge CLK);
        if (mon_en && RESET_N && TX === 1'b0) begin
            repeat (2) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge CLK);
                mon_b[i] = TX;
            end
            repeat (4) @(negedge CLK);
            if (TX === 1'b1) rx_q.push_back(mon_b);
            else rx_bad++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        bus_rd(BASE + 4, rd_v);
        check("rst_status", rd_v, 32'h4);
        bus_rd(BASE + 8, rd_v);
        check("rst_ctrl", rd_v, 32'h0);
        check("rst_tx", 32'(TX), 32'h1);
        check("rst_irq", 32'(IRQ), 32'h0);

        bus_wr(BASE, 32'h3C);
        repeat (9) @(negedge CLK);
        IOBUS_ADDR = BASE + 4;
        #1 check("midframe_status", IOBUS_IN, 32'h5);
        check("midframe_tx", 32'(TX), 32'h0);
        #1 RESET_N = 1'b0;
        #1 check("async_tx", 32'(TX), 32'h1);
        check("async_status", IOBUS_IN, 32'h4);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_tx", 32'(TX), 32'h1);
        mon_en = 1'b1;

        bus_wr(BASE, 32'hA5);
        check("a5_pre", 32'(TX), 32'h1);
        check_line("a5_line", {10'h0, 1'b1, 8'hA5, 1'b0}, 10, 1);
        repeat (5) @(negedge CLK);
        check("a5_rx_n", rx_q.size(), 1);
        check("a5_rx", 32'(rx_q[0]), 32'hA5);
        rx_q.delete();

        @(negedge CLK);
        IOBUS_ADDR = BASE;
        IOBUS_OUT  = 32'h55;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_OUT  = 32'hAA;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        check_line("b2b_line", {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}, 20, 2);
        repeat (45) @(negedge CLK);
        check("b2b_rx_n", rx_q.size(), 2);
        check("b2b_rx0", 32'(rx_q[0]), 32'h55);
        check("b2b_rx1", 32'(rx_q[1]), 32'hAA);
        rx_q.delete();

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            IOBUS_ADDR = BASE;
            IOBUS_OUT  = 32'h10 + i;
            IOBUS_WR   = 1'b1;
        end
        @(negedge CLK);
        IOBUS_WR = 1'b0;
        bus_rd(BASE + 4, rd_v);
        check("ovf_status", rd_v, 32'h10B);
        bus_wr(BASE + 4, 32'h8);
        bus_rd(BASE + 4, rd_v);
        check("ovf_clear", rd_v, 32'h103);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            bus_rd(BASE + 4, rd_v);
            done = (rd_v == 32'h4);
        end
        check("drain_status", rd_v, 32'h4);
        check("ovf_rx_n", rx_q.size(), 17);
        for (int i = 0; i < 17; i++) check("ovf_rx", 32'(rx_q[i]), 32'h10 + i);
        rx_q.delete();

        bus_wr(BASE + 8, 32'h1);
        check("irq_idle", 32'(IRQ), 32'h1);
        bus_rd(BASE + 8, rd_v);
        check("ctrl_rd", rd_v, 32'h1);
        bus_wr(BASE, 32'h5A);
        check("irq_push", 32'(IRQ), 32'h0);
        repeat (20) @(negedge CLK);
        check("irq_frame", 32'(IRQ), 32'h0);
        repeat (25) @(negedge CLK);
        check("irq_done", 32'(IRQ), 32'h1);
        check("irq_rx_n", rx_q.size(), 1);
        check("irq_rx", 32'(rx_q[0]), 32'h5A);
        rx_q.delete();

        bus_rd(BASE + 12, rd_v);
        check("oow_hi_rd", rd_v, 32'h0);
        bus_rd(32'h1100_0000, rd_v);
        check("oow_lo_rd", rd_v, 32'h0);
        bus_rd(BASE, rd_v);
        check("data_rd", rd_v, 32'h0);
        bus_wr(BASE + 12, 32'h0);
        bus_wr(32'h1100_0000, 32'h0);
        bus_rd(BASE + 8, rd_v);
        check("oow_ctrl", rd_v, 32'h1);
        bus_rd(BASE + 4, rd_v);
        check("oow_status", rd_v, 32'h4);
        check("oow_irq", 32'(IRQ), 32'h1);
        bus_wr(BASE + 8, 32'h0);
        check("irq_off", 32'(IRQ), 32'h0);
        repeat (45) @(negedge CLK);
        check("oow_tx", 32'(TX), 32'h1);
        check("oow_rx_n", rx_q.size(), 0);
        check("rx_framing", rx_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
